// File: rtl/pio_out_pulse.sv
// pio_out_pulse: Avalon-MM output port with atomic SET/CLR/TOGGLE and a self-clearing one-shot pulse
module pio_out_pulse #(
  parameter int                WIDTH         = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
  parameter int                CNT_W         = 16,
  parameter int                PULSE_DEFAULT = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);
  logic [WIDTH-1:0] data, mask, wd, data_x, data_n, mask_n;
  logic [CNT_W-1:0] cnt, len, cnt_n, len_n;
  logic             busy, busy_n, wr, go, ex;
  logic [15:0]      cnt16;
  assign wd    = writedata[WIDTH-1:0];
  assign wr    = chipselect & ~write_n;
  assign go    = wr & (address == 3'd4) & |wd;
  assign ex    = busy & ~go & (cnt == CNT_W'(1));
  assign cnt16 = 16'(cnt);
  assign out_port   = data;
  assign pulse_busy = busy;
  // Next state: expiry clear is applied first so a same-edge CPU write wins
  always_comb begin
    data_x = ex ? data & ~mask : data;
    data_n = !wr              ? data_x :
             address == 3'd0  ? wd :
             address == 3'd1  ? data_x | wd :
             address == 3'd2  ? data_x & ~wd :
             address == 3'd3  ? data_x ^ wd :
             address == 3'd4  ? data_x | wd : data_x;
    mask_n = go ? mask | wd : ex ? '0 : mask;
    cnt_n  = go ? (len == '0 ? CNT_W'(1) : len) : ex ? '0 : busy ? cnt - CNT_W'(1) : cnt;
    busy_n = go | (busy & ~ex);
    len_n  = (wr && address == 3'd5) ? writedata[CNT_W-1:0] : len;
  end
  // State registers with synchronous reset that also aborts a running pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
      mask <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      len  <= CNT_W'(PULSE_DEFAULT);
    end else begin
      data <= data_n;
      mask <= mask_n;
      cnt  <= cnt_n;
      busy <= busy_n;
      len  <= len_n;
    end
  end
  // Zero-wait-state read mux; unused bits read as zero
  always_comb begin
    readdata = address <= 3'd3 ? 32'(data) :
               address == 3'd4 ? 32'(mask) :
               address == 3'd5 ? 32'(len) :
               address == 3'd6 ? {cnt16, 15'b0, busy} : 32'd0;
  end
endmodule

// File: tb/tb_pio_out_pulse.sv
// tb_pio_out_pulse: directed scoreboard bench for the pulse-capable output port
module tb_pio_out_pulse;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;
  int          total = 0;
  int          bad = 0;
  typedef struct {logic [31:0] v; string tag;} exp_t;
  exp_t q[$];

  pio_out_pulse #(.WIDTH(8), .RESET_VALUE(8'hA5), .CNT_W(16), .PULSE_DEFAULT(100)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .pulse_busy(pulse_busy)
  );

  always #10 clk = ~clk;

  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.v = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty obs=%h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [7:0] eo, input string tag);
    want(tag, 32'(eo));
    @(negedge clk);
    address = a[2:0];
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
    chk(32'(out_port));
  endtask

  task automatic idle(input logic [7:0] eo, input string tag);
    want(tag, 32'(eo));
    @(posedge clk);
    #1;
    chk(32'(out_port));
  endtask

  task automatic rd(input int a, input logic [31:0] e, input string tag);
    want(tag, e);
    address = a[2:0];
    #1;
    chk(readdata);
  endtask

  task automatic busy_is(input logic e, input string tag);
    want(tag, 32'(e));
    chk(32'(pulse_busy));
  endtask

  initial begin
    // 1 reset state
    repeat (2) @(posedge clk);
    #1;
    want("rst_out", 32'hA5); chk(32'(out_port));
    busy_is(1'b0, "rst_busy");
    rd(6, 32'd0, "rst_status");
    rd(5, 32'd100, "rst_len");
    rd(4, 32'd0, "rst_mask");
    reset = 1'b0;
    // 2 atomic ops
    wr(0, 32'h0F, 8'h0F, "data_0f");
    wr(1, 32'hF0, 8'hFF, "set_f0");
    rd(1, 32'hFF, "rd_set");
    wr(2, 32'h03, 8'hFC, "clr_03");
    rd(2, 32'hFC, "rd_clr");
    wr(3, 32'h81, 8'h7D, "tog_81");
    rd(3, 32'h7D, "rd_tog");
    rd(0, 32'h7D, "rd_data");
    rd(7, 32'd0, "rd_rsvd");
    // PULSE with zero mask does nothing
    wr(4, 32'h0, 8'h7D, "pulse0_out");
    busy_is(1'b0, "pulse0_busy");
    // 3 three-cycle pulse
    wr(0, 32'h0, 8'h00, "clear");
    wr(5, 32'd3, 8'h00, "len3");
    rd(5, 32'd3, "rd_len3");
    wr(4, 32'h01, 8'h01, "p3_k");
    busy_is(1'b1, "p3_busy_k");
    rd(6, 32'h0003_0001, "p3_status_k");
    idle(8'h01, "p3_k1");
    rd(6, 32'h0002_0001, "p3_status_k1");
    idle(8'h01, "p3_k2");
    busy_is(1'b1, "p3_busy_k2");
    idle(8'h00, "p3_k3");
    busy_is(1'b0, "p3_busy_k3");
    // 4 retrigger merges mask and reloads count
    wr(5, 32'd5, 8'h00, "len5");
    wr(4, 32'h01, 8'h01, "rt_a");
    idle(8'h01, "rt_gap");
    wr(4, 32'h02, 8'h03, "rt_b");
    rd(4, 32'h03, "rt_mask");
    for (int i = 0; i < 4; i++) idle(8'h03, "rt_hold");
    rd(4, 32'h03, "rt_mask_late");
    idle(8'h00, "rt_expire");
    busy_is(1'b0, "rt_busy");
    rd(4, 32'h00, "rt_mask_clr");
    // 5 CPU SET wins over expiry on the same edge
    wr(5, 32'd4, 8'h00, "len4");
    wr(4, 32'h10, 8'h10, "ex_k");
    for (int i = 0; i < 3; i++) idle(8'h10, "ex_hold");
    wr(1, 32'h10, 8'h10, "ex_set");
    busy_is(1'b0, "ex_busy");
    rd(4, 32'h00, "ex_mask");
    idle(8'h10, "ex_after");
    // zero length gives a one-cycle pulse
    wr(0, 32'h0, 8'h00, "clear2");
    wr(5, 32'd0, 8'h00, "len0");
    wr(4, 32'h04, 8'h04, "l0_k");
    rd(6, 32'h0001_0001, "l0_status");
    idle(8'h00, "l0_k1");
    busy_is(1'b0, "l0_busy");
    // 6 reset aborts a running pulse
    wr(5, 32'd60, 8'h00, "len60");
    wr(4, 32'h20, 8'h20, "ab_k");
    for (int i = 0; i < 10; i++) idle(8'h20, "ab_hold");
    rd(6, 32'h0032_0001, "ab_status50");
    reset = 1'b1;
    idle(8'hA5, "ab_reset");
    busy_is(1'b0, "ab_busy");
    rd(4, 32'h00, "ab_mask");
    rd(5, 32'd100, "ab_len");
    reset = 1'b0;
    for (int i = 0; i < 60; i++) idle(8'hA5, "ab_noclear");
    busy_is(1'b0, "ab_busy_end");
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
